divisor_secuencial: RTL and testbench
=====================================

# divisor_secuencial

Multi-cycle 32-bit integer divider for the RV32M execute stage, the subtractive counterpart of the single-cycle adder. It computes DIV, DIVU, REM and REMU by restoring shift-and-subtract, one quotient bit per clock. A start/busy/done handshake lets the pipeline control stall the execute stage while the block runs.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk`  in  1  system clock, rising-edge active.
- `rst`  in  1  asynchronous reset, active-high; clears every register.
- `start`  in  1  request a new division; sampled only while `busy`=0.
- `op`  in  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `A`  in  32  dividend (rs1), sampled with `start`.
- `B`  in  32  divisor (rs2), sampled with `start`.
- `busy`  out  1  high from the start edge until the result edge.
- `done`  out  1  one-cycle pulse when `S` holds a new result.
- `S`  out  32  quotient or remainder; holds its value until the next result.

## Operation
- States: IDLE, CALC, FIN.
- **IDLE**, `start`=1:
  - Latch `op`.
  - Signed ops (DIV, REM): store |A| and |B|, and record the quotient sign (A[31]^B[31]) and the remainder sign (A[31]).
  - Unsigned ops: store A and B unchanged.
  - Clear the 33-bit partial remainder and the 5-bit counter.
  - Go to CALC.
- Fast paths, decided in IDLE and going straight to FIN:
  - B=0: quotient = 0xFFFFFFFF, remainder = A.
  - Signed op with A=0x80000000 and B=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- **CALC**, per cycle:
  - Shift the next dividend MSB into the partial remainder.
  - Compute the 33-bit trial difference (remainder − {0,divisor}).
  - If the difference is non-negative (bit 32 = 0), keep it and shift quotient bit 1; otherwise restore and shift 0.
  - Counter increments. On counter = 31 after that iteration, go to FIN.
- **FIN**:
  - Select the quotient (op 00/01) or the remainder (op 10/11).
  - For signed ops, negate the quotient if its sign is set and negate the remainder if A was negative. Fast-path results are used unmodified.
  - Register the result into `S`, pulse `done`, return to IDLE.
- Arithmetic is two's complement modulo 2^32. Negating 0x80000000 yields 0x80000000.
- `start` while `busy`=1 is ignored. It is not queued.
- `start` on the same cycle that `done` is high is accepted, because `busy` is already 0.
- Reset mid-operation aborts the division and returns to IDLE with outputs at reset values.

## Timing
- Reset values: `busy`=0, `done`=0, `S`=0, state IDLE.
- Edge 0 samples `start`; `busy`=1 after edge 0.
- Normal path:
  - Edges 1..32 perform the 32 iterations.
  - Edge 33 is FIN: `S` is valid, `done`=1, `busy`=0.
  - Latency is 33 cycles, start edge to result.
- Fast path: edge 1 is FIN, so latency is 1 cycle.
- `done` is high for exactly one cycle. `S` is stable from the `done` cycle until the next FIN edge.
- The critical path is one 33-bit subtract plus a mux per cycle.

## Structure
- Shared package `riscv_pkg`: op encodings `OP_DIV`, `OP_DIVU`, `OP_REM`, `OP_REMU`; `XLEN`; state enum `div_state_t`.
- Sub-module `restador`: a combinational 33-bit subtractor with outputs `D[32:0]` and `neg`, instantiated once for the trial subtraction.
- No other hierarchy.

## Test plan
- DIVU with A=100, B=7 -> `done` after 33 cycles, S=14; REMU on the same operands -> S=2.
- DIV with A=-100 (0xFFFFFF9C), B=7 -> S=0xFFFFFFF2 (−14); REM on the same operands -> S=0xFFFFFFFE (−2).
- DIV with B=0, A=5 -> `done` after 1 cycle, S=0xFFFFFFFF; REMU with B=0, A=5 -> S=5.
- DIV with A=0x80000000, B=0xFFFFFFFF -> 1 cycle, S=0x80000000; REM on the same operands -> S=0.
- `start` pulsed at cycle 10 of a running DIVU with A=0xFFFFFFFF, B=1 -> ignored; the result at cycle 33 is S=0xFFFFFFFF, followed by one `done` pulse only.
- `rst` asserted at cycle 20 of an operation -> `busy`, `done` and `S` all 0 immediately; a new `start` after release completes normally in 33 cycles.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32M definitions for the execute-stage arithmetic blocks.
// Holds op encodings, the datapath width and the divider state type.
package riscv_pkg;
  localparam int XLEN = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } div_state_t;

  // Two's complement negate; 0x80000000 maps onto itself.
  function automatic logic [XLEN-1:0] neg2(input logic [XLEN-1:0] v);
    return {XLEN{1'b0}} - v;
  endfunction

  function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic en);
    return (en && v[XLEN-1]) ? neg2(v) : v;
  endfunction
endpackage

// File: rtl/divisor_secuencial_restador.sv
// Combinational trial subtractor for the restoring divider.
// neg flags a negative difference, i.e. the divisor did not fit.
module restador #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] D,
  output logic         neg
);
  assign D   = a - b;
  assign neg = D[W-1];
endmodule

// File: rtl/divisor_secuencial.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// state | meaning
// IDLE  | waiting for start; latches operands, resolves B=0 and signed-overflow fast paths
// CALC  | 32 shift-and-subtract iterations
// FIN   | applies result signs, registers S, pulses done
module divisor_secuencial #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] S
);
  import riscv_pkg::*;

  localparam logic [4:0]      LAST    = 5'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state;
  logic [1:0]      op_r;
  logic [XLEN-1:0] dvd;     // dividend shifting out, quotient shifting in
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] rem;
  logic [4:0]      cnt;
  logic            q_neg;
  logic            r_neg;
  logic            fast;

  logic            sgn_in;
  logic            rem_sel;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            neg;
  logic [XLEN-1:0] res;

  assign sgn_in  = (op == OP_DIV) || (op == OP_REM);
  assign rem_sel = (op_r == OP_REM) || (op_r == OP_REMU);
  assign shifted = {rem, dvd[XLEN-1]};

  restador #(.W(XLEN + 1)) u_restador (
    .a   (shifted),
    .b   ({1'b0, dvs}),
    .D   (diff),
    .neg (neg)
  );

  always_comb begin
    res = rem_sel ? rem : dvd;
    if (!fast && (rem_sel ? r_neg : q_neg)) res = neg2(res);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      op_r  <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      fast  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            busy  <= 1'b1;
            cnt   <= '0;
            q_neg <= sgn_in & (A[XLEN-1] ^ B[XLEN-1]);
            r_neg <= sgn_in & A[XLEN-1];
            dvs   <= abs_if(B, sgn_in);
            // fast-path results are preloaded into the quotient/remainder slots
            if (B == '0) begin
              fast  <= 1'b1;
              dvd   <= '1;
              rem   <= A;
              state <= FIN;
            end else if (sgn_in && A == MIN_NEG && B == '1) begin
              fast  <= 1'b1;
              dvd   <= MIN_NEG;
              rem   <= '0;
              state <= FIN;
            end else begin
              fast  <= 1'b0;
              dvd   <= abs_if(A, sgn_in);
              rem   <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= neg ? shifted[XLEN-1:0] : diff[XLEN-1:0];
          dvd <= {dvd[XLEN-2:0], ~diff[XLEN]};
          cnt <= cnt + 5'd1;
          if (cnt == LAST) state <= FIN;
        end
        FIN: begin
          S     <= res;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divisor_secuencial.sv
// Bench for divisor_secuencial: directed RV32M corner cases plus random operands
// checked against an arithmetic reference model.
module tb_divisor_secuencial;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B, S;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  divisor_secuencial #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .S     (S)
  );

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    if (!o[0]) return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    return o[1] ? a % b : a / b;
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // caller is at a negedge; start is sampled by the next rising edge (edge 0)
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 60);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (S !== 32'd0) begin bad++; $display("FAIL reset_S got=%h want=00000000", S); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [1:0]  vo [8] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10};
    logic [31:0] va [8] = '{32'd100, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] vb [8] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ve [8] = '{32'd14, 32'd2, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int          vl [8] = '{33, 33, 33, 33, 1, 1, 1, 1};
    int cyc;
    for (int i = 0; i < 8; i++) begin
      issue(vo[i], va[i], vb[i]);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL dir%0d_busy got=%b want=1", i, busy); end
      wait_done(cyc);
      total++; if (cyc !== vl[i]) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, cyc, vl[i]); end
      total++; if (S !== ve[i]) begin bad++; $display("FAIL dir%0d_S got=%h want=%h", i, S, ve[i]); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL dir%0d_busy_end got=%b want=0", i, busy); end
      @(negedge clk);
      total++; if (done !== 1'b0 || S !== ve[i]) begin bad++; $display("FAIL dir%0d_pulse done=%b S=%h want done=0 S=%h", i, done, S, ve[i]); end
    end
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a, b, exp;
    int cyc, lat;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = (i % 9 == 4) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: b = 32'd0 - 32'($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      exp = model(o, a, b);
      lat = model_lat(o, a, b);
      @(negedge clk);
      issue(o, a, b);
      wait_done(cyc);
      total++; if (cyc !== lat) begin bad++; $display("FAIL rnd%0d_latency op=%b A=%h B=%h got=%0d want=%0d", i, o, a, b, cyc, lat); end
      total++; if (S !== exp) begin bad++; $display("FAIL rnd%0d_S op=%b A=%h B=%h got=%h want=%h", i, o, a, b, S, exp); end
    end
  endtask

  task automatic test_busy_ignore;
    int cyc, extra;
    @(negedge clk);
    issue(2'b01, 32'hFFFF_FFFF, 32'd1);
    cyc = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 9)  begin start = 1'b1; op = 2'b00; A = 32'd5; B = 32'd0; end
      if (cyc == 10) start = 1'b0;
    end
    total++; if (cyc !== 33) begin bad++; $display("FAIL ignore_latency got=%0d want=33", cyc); end
    total++; if (S !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ignore_S got=%h want=ffffffff", S); end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL ignore_extra_done got=%0d want=0", extra); end
    total++; if (S !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ignore_S_hold got=%h want=ffffffff", S); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    @(negedge clk);
    issue(2'b00, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || S !== 32'd0) begin
      bad++; $display("FAIL midrst_outputs busy=%b done=%b S=%h want 0 0 00000000", busy, done, S);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(2'b10, 32'd1000, 32'd3);
    wait_done(cyc);
    total++; if (cyc !== 33) begin bad++; $display("FAIL midrst_latency got=%0d want=33", cyc); end
    total++; if (S !== 32'd1) begin bad++; $display("FAIL midrst_S got=%h want=00000001", S); end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  o;
    logic [31:0] a, b, exp;
    int cyc, lat;
    @(negedge clk);
    issue(2'b01, 32'd12345, 32'd10);
    wait_done(cyc);
    total++; if (S !== 32'd1234) begin bad++; $display("FAIL b2b_first_S got=%h want=%h", S, 32'd1234); end
    for (int i = 0; i < 4; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 1) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      exp = model(o, a, b);
      lat = model_lat(o, a, b);
      issue(o, a, b);
      wait_done(cyc);
      total++; if (cyc !== lat) begin bad++; $display("FAIL b2b%0d_latency got=%0d want=%0d", i, cyc, lat); end
      total++; if (S !== exp) begin bad++; $display("FAIL b2b%0d_S op=%b A=%h B=%h got=%h want=%h", i, o, a, b, S, exp); end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_busy_ignore;
    test_reset_mid;
    test_back_to_back;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
